// File: rtl/tpiu_frame_decoder.sv
// tpiu_frame_decoder: CoreSight TPIU 16-byte formatter frame decoder with ping-pong frame buffering.
// Optional feature macro: TPIU_DROP_NULL_ID_EN suppresses data bytes whose effective ID is 0x00 or 0x7F.
module tpiu_frame_decoder #(
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               dIn,
    input  logic                     dInValid,
    input  logic                     sync,
    output logic [7:0]               oData,
    output logic [6:0]               oId,
    output logic                     oValid,
    input  logic                     oReady,
    output logic                     overflow,
    output logic [OVF_CNT_WIDTH-1:0] ovfCount
);
    typedef enum logic {IDLE, RUN} stateT;

    logic [7:0] frameBuf [2][16];
    logic       colSel;
    logic [3:0] fillIdx;
    logic       accept;
    logic       lastByte;
    logic       handoff;
    logic       drop;
    stateT      state;
    stateT      nextState;
    logic [3:0] slot;
    logic [3:0] nextSlot;
    logic [6:0] curId;
    logic [6:0] nextCurId;
    logic [7:0] curByte;
    logic [7:0] pairByte;
    logic       auxBit;
    logic       isData;
    logic       emit;
    logic       advance;
    logic       done;
    logic [7:0] stepData;
    logic [6:0] stepId;

    assign accept   = dInValid && sync;
    assign lastByte = accept && (fillIdx == 4'd15);
    assign handoff  = lastByte && (state == IDLE || done);
    assign drop     = lastByte && !handoff;
    assign curByte  = frameBuf[~colSel][slot];
    assign pairByte = frameBuf[~colSel][slot + 4'd1];
    assign auxBit   = frameBuf[~colSel][15][slot[3:1]];

    // Collector write port into the buffer it currently owns
    always_ff @(posedge clk) begin
        if (accept) frameBuf[colSel][fillIdx] <= dIn;
    end

    // Collector fill index, buffer ownership swap and dropped-frame accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            fillIdx  <= 4'd0;
            colSel   <= 1'b0;
            overflow <= 1'b0;
            ovfCount <= '0;
        end else begin
            fillIdx  <= !sync ? 4'd0 : (accept ? fillIdx + 4'd1 : fillIdx);
            colSel   <= colSel ^ handoff;
            overflow <= drop;
            ovfCount <= (drop && !(&ovfCount)) ? ovfCount + {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1} : ovfCount;
        end
    end

    // Emitter state register with slot pointer and persistent stream ID
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot  <= 4'd0;
            curId <= 7'd0;
        end else begin
            state <= nextState;
            slot  <= handoff ? 4'd0 : (advance ? nextSlot : slot);
            curId <= advance ? nextCurId : ((!sync && state == IDLE) ? 7'd0 : curId);
        end
    end

    // Emitter next state: a handoff always (re)starts RUN, even on the completing cycle
    always_comb begin
        nextState = handoff ? RUN : (done ? IDLE : state);
    end

    // Emitter slot decode; an ID change is folded with its odd partner so it costs no output cycle
    always_comb begin
        isData    = 1'b0;
        stepData  = curByte;
        stepId    = curId;
        nextCurId = curId;
        nextSlot  = slot + 4'd1;
        if (slot[0]) begin
            isData = 1'b1;
        end else if (!curByte[0]) begin
            isData   = 1'b1;
            stepData = {curByte[7:1], auxBit};
        end else begin
            nextCurId = curByte[7:1];
            if (slot != 4'd14) begin
                isData   = 1'b1;
                stepData = pairByte;
                stepId   = auxBit ? curId : curByte[7:1];
                nextSlot = slot + 4'd2;
            end
        end
`ifdef TPIU_DROP_NULL_ID_EN
        emit = isData && stepId != 7'h00 && stepId != 7'h7F;
`else
        emit = isData;
`endif
        advance = (state == RUN) && (!emit || !oValid || oReady);
        done    = advance && (slot == 4'd14);
    end

    // Output register, held while stalled by the downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            oValid <= 1'b0;
            oData  <= 8'h00;
            oId    <= 7'h00;
        end else if (advance && emit) begin
            oValid <= 1'b1;
            oData  <= stepData;
            oId    <= stepId;
        end else if (oReady) begin
            oValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tpiu_frame_decoder.sv
// tb_tpiu_frame_decoder: directed bench with a frame-level reference decoder and per-cycle output checker.
module tb_tpiu_frame_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dIn;
    logic        dInValid;
    logic        sync;
    logic [7:0]  oData;
    logic [6:0]  oId;
    logic        oValid;
    logic        oReady;
    logic        overflow;
    logic [15:0] ovfCount;

    typedef struct packed {
        logic [6:0] id;
        logic [7:0] d;
    } pairT;

    int         tests = 0;
    int         fails = 0;
    int         ovfPulses = 0;
    pairT       expQ[$];
    pairT       gotQ[$];
    logic [7:0] frame [16];
    logic [6:0] mId;
    bit         randReady = 0;
    logic       stallV = 1'b0;
    logic [7:0] sD;
    logic [6:0] sI;

    tpiu_frame_decoder #(.OVF_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .dIn(dIn), .dInValid(dInValid), .sync(sync),
        .oData(oData), .oId(oId), .oValid(oValid), .oReady(oReady),
        .overflow(overflow), .ovfCount(ovfCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [6:0] id, input logic [7:0] d);
`ifdef TPIU_DROP_NULL_ID_EN
        if (id == 7'h00 || id == 7'h7F) return;
`endif
        expQ.push_back({id, d});
    endfunction

    // Reference decode of one whole frame, pair by pair, straight from the formatter rules
    function automatic void modelFrame();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            logic       a;
            e = frame[2*k];
            a = frame[15][k];
            if (k == 7) begin
                if (e[0]) mId = e[7:1];
                else push(mId, {e[7:1], a});
            end else if (!e[0]) begin
                push(mId, {e[7:1], a});
                push(mId, frame[2*k+1]);
            end else if (!a) begin
                mId = e[7:1];
                push(mId, frame[2*k+1]);
            end else begin
                push(mId, frame[2*k+1]);
                mId = e[7:1];
            end
        end
    endfunction

    task automatic sendByte(input logic [7:0] b);
        dIn = b;
        dInValid = 1'b1;
        @(posedge clk);
        #1;
        dInValid = 1'b0;
    endtask

    task automatic sendFrame(input bit expectDrop, input int stallAt);
        for (int i = 0; i < 16; i++) begin
            if (randReady) oReady = 1'($urandom_range(0, 1));
            else if (stallAt >= 0) oReady = (i != stallAt);
            sendByte(frame[i]);
        end
        if (!expectDrop) modelFrame();
    endtask

    task automatic clearFrame();
        for (int i = 0; i < 16; i++) frame[i] = 8'h00;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || oValid) && n < budget) begin
            if (randReady) oReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
        oReady = 1'b1;
    endtask

    // Per-cycle output checker: handshakes against the reference queue, stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            stallV = 1'b0;
        end else begin
            if (overflow) ovfPulses++;
            if (stallV) begin
                check("stall_valid", 32'(oValid), 32'd1);
                check("stall_data", 32'(oData), 32'(sD));
                check("stall_id", 32'(oId), 32'(sI));
            end
            if (oValid && oReady) begin
                gotQ.push_back({oId, oData});
                if (expQ.size() == 0) begin
                    check("unexpected_out", 32'({oId, oData}), 32'hFFFFFFFF);
                end else begin
                    pairT e;
                    e = expQ.pop_front();
                    check("out_id", 32'(oId), 32'(e.id));
                    check("out_data", 32'(oData), 32'(e.d));
                end
            end
            stallV = oValid && !oReady;
            sD = oData;
            sI = oId;
        end
    end

    initial begin
        int cnt;
        rst = 1'b1;
        dIn = 8'h00;
        dInValid = 1'b0;
        sync = 1'b0;
        oReady = 1'b0;
        mId = 7'h00;
        repeat (3) begin
            dIn = 8'($urandom);
            dInValid = 1'($urandom_range(0, 1));
            sync = 1'($urandom_range(0, 1));
            oReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        check("rst_oValid", 32'(oValid), 32'd0);
        check("rst_oData", 32'(oData), 32'd0);
        check("rst_oId", 32'(oId), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ovfCount", 32'(ovfCount), 32'd0);
        rst = 1'b0;
        dInValid = 1'b0;
        sync = 1'b0;
        oReady = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (oValid) cnt++;
        end
        check("rst_quiet", 32'(cnt), 32'd0);

        // Basic frame with latency check
        sync = 1'b1;
        @(posedge clk);
        #1;
        clearFrame();
        frame[0] = 8'h21;
        frame[1] = 8'hAA;
        frame[2] = 8'h44;
        frame[3] = 8'h55;
        gotQ.delete();
        sendFrame(0, -1);
        check("lat_n1", 32'(oValid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_n2", 32'(oValid), 32'd1);
        drain(200);
        check("basic_count", 32'(gotQ.size()), 32'd14);
        check("basic_0", 32'(gotQ[0]), 32'({7'h10, 8'hAA}));
        check("basic_1", 32'(gotQ[1]), 32'({7'h10, 8'h44}));
        check("basic_2", 32'(gotQ[2]), 32'({7'h10, 8'h55}));
        check("basic_13", 32'(gotQ[13]), 32'({7'h10, 8'h00}));

        // Delayed ID and LSB-in-aux
        clearFrame();
        frame[0] = 8'h21;
        frame[1] = 8'h11;
        frame[2] = 8'h31;
        frame[3] = 8'h77;
        frame[4] = 8'h40;
        frame[5] = 8'h12;
        frame[15] = 8'h06;
        gotQ.delete();
        sendFrame(0, -1);
        drain(200);
        check("dly_count", 32'(gotQ.size()), 32'd13);
        check("dly_1", 32'(gotQ[1]), 32'({7'h10, 8'h77}));
        check("dly_2", 32'(gotQ[2]), 32'({7'h18, 8'h41}));
        check("dly_3", 32'(gotQ[3]), 32'({7'h18, 8'h12}));

        // Overflow: second frame dropped while first is stalled
        oReady = 1'b0;
        clearFrame();
        frame[0] = 8'h21;
        frame[1] = 8'hAA;
        frame[2] = 8'h44;
        frame[3] = 8'h55;
        gotQ.delete();
        sendFrame(0, -1);
        check("ovf_none_yet", 32'(ovfCount), 32'd0);
        for (int i = 0; i < 16; i++) frame[i] = 8'(8'h06 + 2 * i);
        sendFrame(1, -1);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(ovfCount), 32'd1);
        @(posedge clk);
        #1;
        check("ovf_pulse_end", 32'(overflow), 32'd0);
        oReady = 1'b1;
        drain(200);
        check("ovf_out_count", 32'(gotQ.size()), 32'd14);
        check("ovf_pulses", 32'(ovfPulses), 32'd1);

        // Backpressure with random oReady
        clearFrame();
        frame[0] = 8'h21;
        for (int i = 1; i < 15; i++) frame[i] = 8'(i * 16 + i + (i % 2 == 0 ? 0 : 1)) & (i % 2 == 0 ? 8'hFE : 8'hFF);
        frame[15] = 8'h5A;
        randReady = 1;
        sendFrame(0, -1);
        drain(500);
        randReady = 0;

        // Back-to-back data frames; a single stall makes completion coincide with the next handoff
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 15; i++) frame[i] = (i % 2 == 0) ? 8'(8'h20 + 6 * i + 16 * f) : 8'(8'h41 + 3 * i + f);
            frame[15] = 8'hA5;
            sendFrame(0, f == 1 ? 5 : 16);
        end
        oReady = 1'b1;
        drain(200);
        check("b2b_ovfCount", 32'(ovfCount), 32'd1);
        check("b2b_pulses", 32'(ovfPulses), 32'd1);

        // Sync loss: partial frame discarded, curId cleared while idle
        clearFrame();
        for (int i = 0; i < 7; i++) sendByte(8'(8'h23 + i));
        sync = 1'b0;
        mId = 7'h00;
        repeat (5) begin
            dIn = 8'($urandom);
            dInValid = 1'b1;
            @(posedge clk);
            #1;
        end
        dInValid = 1'b0;
        sync = 1'b1;
        frame[0] = 8'h44;
        frame[1] = 8'h55;
        frame[2] = 8'h25;
        frame[3] = 8'h66;
        gotQ.delete();
        sendFrame(0, -1);
        drain(200);
        check("sync_count", 32'(gotQ.size()), 32'd14);
        check("sync_0", 32'(gotQ[0]), 32'({7'h00, 8'h44}));
        check("sync_1", 32'(gotQ[1]), 32'({7'h00, 8'h55}));
        check("sync_2", 32'(gotQ[2]), 32'({7'h12, 8'h66}));
        check("final_queue", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
